// File: rtl/intra_pred_pkg.sv
// intra_pred_pkg: shared types and DC rounding for the intra prediction blocks
package intra_pred_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, CALC, EMIT} state_t;
  typedef enum logic [1:0] {MODE_V, MODE_H, MODE_DC, MODE_RSVD} mode_t;
  function automatic int unsigned dc_round(input int unsigned sum, input int unsigned lg,
                                           input logic top, input logic left, input int unsigned pix_w);
    return top && left ? (sum + (32'd1 << lg)) >> (lg + 1) :
           top || left ? (sum + (32'd1 << (lg - 1))) >> lg :
           32'd1 << (pix_w - 1);
  endfunction
endpackage

// File: rtl/intra_dc_calc.sv
// intra_dc_calc: rounded DC average of the available neighbour edges
module intra_dc_calc
  import intra_pred_pkg::*;
#(
  parameter int BLK = 16,
  parameter int PIX_W = 8
) (
  input  logic [PIX_W+5:0] sum,
  input  logic             top_avail,
  input  logic             left_avail,
  output logic [PIX_W-1:0] dc
);
  assign dc = PIX_W'(dc_round(32'(sum), $clog2(BLK), top_avail, left_avail, PIX_W));
endmodule

// File: rtl/intra_pred_nxn.sv
// intra_pred_nxn: vertical/horizontal/DC intra predictor for one BLKxBLK block,
// loading 2*BLK neighbours then emitting one prediction row per handshake.
module intra_pred_nxn
  import intra_pred_pkg::*;
#(
  parameter int BLK = 16,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic               top_avail,
  input  logic               left_avail,
  input  logic               nb_valid,
  input  logic [PIX_W-1:0]   nb_data,
  output logic               nb_ready,
  output logic [BLK*PIX_W-1:0] row_data,
  output logic [3:0]         row_idx,
  output logic               row_valid,
  input  logic               row_ready,
  output logic               busy,
  output logic               done
);
  localparam int SW = PIX_W + 6;
  localparam int LW = $clog2(BLK);
  state_t state, state_n;
  mode_t mode_r;
  logic top_av, left_av, accept, xfer, last_pix;
  logic [5:0] cnt;
  logic [SW-1:0] sum;
  logic [PIX_W-1:0] dc;
  logic [PIX_W-1:0] top_pix [BLK];
  logic [PIX_W-1:0] left_pix [BLK];
  logic [3:0] nxt_idx;
  logic [BLK*PIX_W-1:0] nxt_row;
  assign nb_ready = state == LOAD;
  assign row_valid = state == EMIT;
  assign busy = state != IDLE;
  assign accept = nb_valid && nb_ready;
  assign last_pix = cnt == 6'(2*BLK-1);
  assign xfer = row_valid && row_ready;
  assign done = xfer && row_idx == 4'(BLK-1);
  assign nxt_idx = state == CALC ? 4'd0 : row_idx + 4'd1;
  intra_dc_calc #(.BLK(BLK), .PIX_W(PIX_W)) u_dc (
    .sum(sum), .top_avail(top_av), .left_avail(left_av), .dc(dc)
  );
  always_comb begin
    state_n = state == IDLE ? (start ? LOAD : IDLE) :
              state == LOAD ? (accept && last_pix ? CALC : LOAD) :
              state == CALC ? EMIT : (done ? IDLE : EMIT);
  end
  // Row for the index about to be presented: row 0 leaving CALC, next row on each transfer
  always_comb begin
    nxt_row = '0;
    for (int i = 0; i < BLK; i++)
      nxt_row[i*PIX_W +: PIX_W] = mode_r == MODE_V && top_av ? top_pix[i] :
                                  mode_r == MODE_H && left_av ? left_pix[nxt_idx[LW-1:0]] : dc;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mode_r <= MODE_V;
      top_av <= 1'b0;
      left_av <= 1'b0;
      cnt <= '0;
      sum <= '0;
      row_idx <= '0;
      row_data <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        mode_r <= mode_t'(mode);
        top_av <= top_avail;
        left_av <= left_avail;
        cnt <= '0;
        sum <= '0;
      end
      if (accept) begin
        cnt <= cnt + 6'd1;
        sum <= sum + ((cnt[LW] ? left_av : top_av) ? SW'(nb_data) : '0);
      end
      if (state == CALC || xfer) begin
        row_data <= nxt_row;
        row_idx <= nxt_idx;
      end
    end
  end
  // Neighbour storage needs no reset; it is always rewritten before use
  always_ff @(posedge clk) begin
    if (accept) begin
      if (cnt[LW]) left_pix[cnt[LW-1:0]] <= nb_data;
      else top_pix[cnt[LW-1:0]] <= nb_data;
    end
  end
endmodule

// File: tb/tb_intra_pred_nxn.sv
// tb_intra_pred_nxn: directed checks of intra_pred_nxn at BLK=4/8/16 with hand-computed rows
module tb_intra_pred_nxn;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] go = '0;
  logic [1:0] mode = '0;
  logic top_avail = 1'b0, left_avail = 1'b0, nb_valid = 1'b0, row_ready = 1'b1;
  logic [9:0] nb_data = '0;
  wire [2:0] nr, rv, bz, dn;
  wire [3:0] ri0, ri1, ri2;
  wire [31:0] rd0;
  wire [63:0] rd1;
  wire [159:0] rd2;
  int pix[32];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  intra_pred_nxn #(.BLK(4), .PIX_W(8)) u4 (
    .clk(clk), .reset(reset), .start(go[0]), .mode(mode), .top_avail(top_avail), .left_avail(left_avail),
    .nb_valid(nb_valid), .nb_data(nb_data[7:0]), .nb_ready(nr[0]), .row_data(rd0), .row_idx(ri0),
    .row_valid(rv[0]), .row_ready(row_ready), .busy(bz[0]), .done(dn[0]));
  intra_pred_nxn #(.BLK(8), .PIX_W(8)) u8 (
    .clk(clk), .reset(reset), .start(go[1]), .mode(mode), .top_avail(top_avail), .left_avail(left_avail),
    .nb_valid(nb_valid), .nb_data(nb_data[7:0]), .nb_ready(nr[1]), .row_data(rd1), .row_idx(ri1),
    .row_valid(rv[1]), .row_ready(row_ready), .busy(bz[1]), .done(dn[1]));
  intra_pred_nxn #(.BLK(16), .PIX_W(10)) u16 (
    .clk(clk), .reset(reset), .start(go[2]), .mode(mode), .top_avail(top_avail), .left_avail(left_avail),
    .nb_valid(nb_valid), .nb_data(nb_data), .nb_ready(nr[2]), .row_data(rd2), .row_idx(ri2),
    .row_valid(rv[2]), .row_ready(row_ready), .busy(bz[2]), .done(dn[2]));
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [159:0] row_now(input int s);
    return s == 0 ? 160'(rd0) : s == 1 ? 160'(rd1) : rd2;
  endfunction
  function automatic int pix_of(input int s, input int i);
    logic [159:0] v = row_now(s);
    return s == 2 ? int'(v[i*10 +: 10]) : int'(v[i*8 +: 8]);
  endfunction
  function automatic int idx_of(input int s);
    return s == 0 ? int'(ri0) : s == 1 ? int'(ri1) : int'(ri2);
  endfunction
  // Caller must be at a negedge; returns at the negedge following the last transfer
  task automatic run_block(input int s, input int blk, input int m, input logic ta, input logic la,
                           input int exp_dc, input logic [31:0] gaps, input int stall_row,
                           input int abort_row, input int exp_lat);
    int w, e;
    longint t0;
    logic [159:0] snap;
    mode = 2'(m); top_avail = ta; left_avail = la; go = '0; go[s] = 1'b1; row_ready = 1'b1;
    t0 = $time;
    for (int k = 0; k < 2*blk; k++) begin
      @(negedge clk);
      go = '0;
      if (k == 0) check("nb_ready_in_load", nr[s], 1);
      if (gaps[k]) begin
        nb_valid = 1'b0;
        @(negedge clk);
      end
      nb_valid = 1'b1;
      nb_data = 10'(pix[k]);
    end
    @(negedge clk);
    nb_valid = 1'b0;
    w = 0;
    while (!rv[s] && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("first_row_latency", int'(($time - t0) / 10), exp_lat);
    for (int r = 0; r < blk; r++) begin
      w = 0;
      while (!rv[s] && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) begin
        check("row_valid_timeout", 0, 1);
        return;
      end
      if (r == abort_row) begin
        #2 reset = 1'b1;
        #1 check("abort_row_valid", rv[s], 0);
        check("abort_busy", bz[s], 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        w = 0;
        repeat (6) begin
          @(negedge clk);
          w += int'(rv[s]) + int'(dn[s]);
        end
        check("no_rows_after_abort", w, 0);
        return;
      end
      check("row_idx", idx_of(s), r);
      check("busy_in_emit", bz[s], 1);
      for (int i = 0; i < blk; i++) begin
        e = (m == 0 && ta) ? pix[i] : (m == 1 && la) ? pix[blk + r] : exp_dc;
        check($sformatf("row%0d_pix%0d", r, i), pix_of(s, i), e);
      end
      if (r == stall_row) begin
        row_ready = 1'b0;
        snap = row_now(s);
        repeat (3) begin
          @(negedge clk);
          check("stall_idx", idx_of(s), r);
          check("stall_valid", rv[s], 1);
          check("stall_data_changed", int'(row_now(s) != snap), 0);
          check("stall_done", dn[s], 0);
        end
        row_ready = 1'b1;
      end
      check("done", dn[s], int'(r == blk - 1));
      @(negedge clk);
    end
    check("idle_after_done", bz[s], 0);
    check("done_one_cycle", dn[s], 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("rst_busy", bz[s], 0);
      check("rst_row_valid", rv[s], 0);
      check("rst_nb_ready", nr[s], 0);
      check("rst_done", dn[s], 0);
      check("rst_row_idx", idx_of(s), 0);
      check("rst_row_data_zero", int'(row_now(s) == '0), 1);
    end
    reset = 1'b0;
    @(negedge clk);
    // BLK=4 DC, both available, all 100
    for (int k = 0; k < 8; k++) pix[k] = 100;
    run_block(0, 4, 2, 1'b1, 1'b1, 100, 32'h0, -1, -1, 10);
    // back-to-back start: BLK=4 vertical with a 3-cycle stall on row 1
    for (int k = 0; k < 4; k++) pix[k] = 10 * (k + 1);
    for (int k = 4; k < 8; k++) pix[k] = 99;
    run_block(0, 4, 0, 1'b1, 1'b1, 0, 32'h0, 1, -1, 10);
    // BLK=8 DC, top only, top=0..7 -> (28+4)>>3 = 4
    for (int k = 0; k < 8; k++) pix[k] = k;
    for (int k = 8; k < 16; k++) pix[k] = 200;
    run_block(1, 8, 2, 1'b1, 1'b0, 4, 32'h0, -1, -1, 18);
    // BLK=8 horizontal, left=1..8, two nb_valid gaps -> latency 18+2
    for (int k = 0; k < 8; k++) pix[k] = 50;
    for (int k = 8; k < 16; k++) pix[k] = k - 7;
    run_block(1, 8, 1, 1'b1, 1'b1, 0, 32'h0000_0804, -1, -1, 20);
    // BLK=16 PIX_W=10 DC, neither available -> 512
    for (int k = 0; k < 32; k++) pix[k] = 7 * k;
    run_block(2, 16, 2, 1'b0, 1'b0, 512, 32'h0, -1, -1, 34);
    // reset during EMIT row 2 abandons the block
    for (int k = 0; k < 8; k++) pix[k] = 100;
    run_block(0, 4, 2, 1'b1, 1'b1, 100, 32'h0, -1, 2, 10);
    // reserved mode acts as DC: sum 36 -> (36+4)>>3 = 5
    for (int k = 0; k < 8; k++) pix[k] = k + 1;
    run_block(0, 4, 3, 1'b1, 1'b1, 5, 32'h0, -1, -1, 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
